game_tick_gen: RTL

- Consumer end of the clock-divider outputs.
- Takes one free-running divided clock bit (nominally the ~100 Hz tap), synchronises it into the system clock domain and converts its rising edges into single-cycle scan strobes.
- Counts scan strobes against a speed-level period table and issues one-cycle game-step ticks for the snake movement logic.
- Sits between the clock divider and the game FSM, so all downstream logic runs on clk with enables instead of derived clocks.

---
 rtl/game_pkg.sv | 9 +
 rtl/sync_edge_detect.sv | 29 ++
 rtl/game_tick_gen.sv | 78 +++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared FSM states, level type and per-level step periods
// (measured in scan strobes) for the game tick logic.
package game_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  typedef logic [1:0] level_t;
  function automatic int unsigned period(level_t l);
    return l == 2'd0 ? 32 : l == 2'd1 ? 24 : l == 2'd2 ? 16 : 8;
  endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchroniser with a registered rising-edge strobe.
// A high input at reset release is not reported as an edge.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic [STAGES-1:0] sync_q, fill_q;
  logic prev_q, rise_q, s, valid;
  assign s = sync_q[STAGES-1];
  assign valid = fill_q[STAGES-1];
  // prev stays 1 until the chain holds real samples, so flushed reset zeros never look like an edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      fill_q <= {fill_q[STAGES-2:0], 1'b1};
      prev_q <= valid ? s : 1'b1;
      rise_q <= valid & s & ~prev_q;
    end
  assign rise_o = rise_q;
endmodule

// File: rtl/game_tick_gen.sv
// game_tick_gen: turns the divided slow clock into scan strobes and
// level-dependent one-cycle game-step ticks, all on clk.
module game_tick_gen
  import game_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 6,
  parameter int TICK_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  slow_clk_in,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  load_level,
  input  logic [1:0]            speed_level,
  input  logic                  speed_up,
  output logic                  scan_tick,
  output logic                  tick,
  output logic [1:0]            level_out,
  output logic                  running,
  output logic [TICK_CNT_W-1:0] tick_count
);
  state_t state_q, state_d;
  level_t level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, last;
  logic [TICK_CNT_W-1:0] tick_count_q;
  logic tick_q, tick_d, scan_q, lw;
  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (slow_clk_in),
    .rise_o (scan_q)
  );
  assign lw = load_level | speed_up;
  assign last = CNT_W'(period(level_q) - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    tick_d = 1'b0;
    level_d = load_level ? speed_level : (speed_up && level_q != 2'd3) ? level_q + 2'd1 : level_q;
    case (state_q)
      IDLE: state_d = start ? RUN : IDLE;
      RUN:
        if (pause) state_d = PAUSE;
        else if (scan_q) begin
          tick_d = cnt_q == last;
          cnt_d = tick_d ? '0 : cnt_q + 1'b1;
        end
      PAUSE: state_d = pause ? PAUSE : RUN;
      default: state_d = IDLE;
    endcase
    // a level write restarts the period and swallows any coincident strobe
    if (lw) begin
      cnt_d = '0;
      tick_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
      cnt_q <= '0;
      tick_q <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q <= cnt_d;
      tick_q <= tick_d;
      tick_count_q <= tick_count_q + TICK_CNT_W'(tick_q);
    end
  assign scan_tick = scan_q;
  assign tick = tick_q;
  assign level_out = level_q;
  assign running = state_q == RUN;
  assign tick_count = tick_count_q;
endmodule
